// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int DEF_ADDR_W   = 32;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_MAX_WAIT = 8;

    // Wide enough for any starvation limit in 1..255.
    localparam int WAIT_W = 8;

    // ARB: normal arbitration. DBG_LOCK: debug loader holds the bus.
    typedef enum logic {
        ARB      = 1'b0,
        DBG_LOCK = 1'b1
    } arb_state_e;

    // Encoding of the owner output.
    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_DBG = 1'b1
    } owner_e;

endpackage

// File: rtl/dmem_arb_wait_cnt.sv
// Debug-port starvation counter: counts cycles where the debug port asks
// but is not granted, saturates at MAX_WAIT, clears on any debug accept.
module dmem_arb_wait_cnt
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic clk,
    input  logic reset,
    input  logic dbg_req,
    input  logic dbg_gnt,
    output logic starved
);

    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] cnt_q;
    logic [WAIT_W-1:0] cnt_d;

    // Next count: clear on debug accept, else count a refused request.
    always_comb begin
        cnt_d = cnt_q;
        if (dbg_req && dbg_gnt) begin
            cnt_d = '0;
        end else if (dbg_req && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + WAIT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign starved = (cnt_q == LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (CPU, debug loader) arbiter in front of a single data memory.
// CPU has priority in ARB; a locked debug access holds the bus in DBG_LOCK.
// Optional debug starvation guard: define DMEM_ARB_STARVE_EN.
//
// Handshake: an access is accepted at a rising edge where req && gnt.
// gnt is combinational from req and registered state, never waits on
// anything else, and at most one gnt is high per cycle. Reads return one
// cycle after the accept edge as a single-cycle rvalid pulse.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic              dbg_lock,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner,
    output arb_state_e        arb_state
);

    if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
        $error("dmem_arbiter: MAX_WAIT must be in 1..255");
    end

    arb_state_e        state_q, state_d;
    logic              cpu_rvalid_q, cpu_rvalid_d;
    logic              dbg_rvalid_q, dbg_rvalid_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
    logic              starved;

`ifdef DMEM_ARB_STARVE_EN
    dmem_arb_wait_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_cnt (
        .clk     (clk),
        .reset   (reset),
        .dbg_req (dbg_req),
        .dbg_gnt (dbg_gnt),
        .starved (starved)
    );
`else
    assign starved = 1'b0;
`endif

    // Grant selection and next state; nothing is granted while in reset.
    always_comb begin
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        state_d = state_q;
        if (reset) begin
            case (state_q)
                ARB: begin
                    if (starved && dbg_req) begin
                        dbg_gnt = 1'b1;
                    end else if (cpu_req) begin
                        cpu_gnt = 1'b1;
                    end else if (dbg_req) begin
                        dbg_gnt = 1'b1;
                    end
                    if (dbg_gnt && dbg_lock) begin
                        state_d = DBG_LOCK;
                    end
                end
                DBG_LOCK: begin
                    dbg_gnt = dbg_req;
                    if (!dbg_lock) begin
                        state_d = ARB;
                    end
                end
                default: state_d = ARB;
            endcase
        end
    end

    // Memory-side mux: follows the granted port, all zero when idle.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_read  = !cpu_we;
            mem_write = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dbg_gnt) begin
            mem_read  = !dbg_we;
            mem_write = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end
    end

    // Read return: capture data on a read accept, pulse rvalid once.
    always_comb begin
        cpu_rvalid_d = cpu_req && cpu_gnt && !cpu_we;
        dbg_rvalid_d = dbg_req && dbg_gnt && !dbg_we;
        cpu_rdata_d  = cpu_rvalid_d ? mem_rdata : cpu_rdata_q;
        dbg_rdata_d  = dbg_rvalid_d ? mem_rdata : dbg_rdata_q;
    end

    // State and read-return registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ARB;
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            dbg_rvalid_q <= dbg_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

    assign owner      = ((state_q == DBG_LOCK) || dbg_gnt) ? OWNER_DBG : OWNER_CPU;
    assign cpu_rvalid = cpu_rvalid_q;
    assign dbg_rvalid = dbg_rvalid_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign dbg_rdata  = dbg_rdata_q;
    assign arb_state  = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic, checked
// against a transaction-level model of who owns the bus each cycle.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 3;

    logic              clk;
    logic              reset;
    logic              cpu_req, cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt, cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              dbg_req, dbg_we, dbg_lock;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt, dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;
    logic              mem_read, mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              owner;
    arb_state_e        arb_state;

    dmem_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_lock   (dbg_lock),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_gnt    (dbg_gnt),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .owner      (owner),
        .arb_state  (arb_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory behind the arbiter ----------------
    function automatic logic [DATA_W-1:0] init_word(input int i);
        if (i == 4) return 32'hDEAD_BEEF;
        return 32'h1000_0000 + DATA_W'(i) * 32'h0101_0011;
    endfunction

    logic [DATA_W-1:0] mem [16];
    initial for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
    always @(posedge clk) if (mem_write) mem[mem_addr[5:2]] <= mem_wdata;
    assign mem_rdata = mem[mem_addr[5:2]];

    // ---------------- reference model / scoreboard ----------------
    logic [DATA_W-1:0] exp_mem [16];
    bit                m_locked;
    int                m_wait;
    logic [DATA_W:0]   exp_q[$];   // {is_dbg, data} read responses due next cycle
    logic [DATA_W-1:0] m_cpu_rdata, m_dbg_rdata;
    int                n_checks, n_errors;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked    = 1'b0;
        m_wait      = 0;
        exp_q.delete();
        m_cpu_rdata = '0;
        m_dbg_rdata = '0;
    endtask

    // Who owns the bus this cycle: 0 none, 1 cpu, 2 debug.
    function automatic int winner(input bit cr, input bit dr);
        if (m_locked) return dr ? 2 : 0;
`ifdef DMEM_ARB_STARVE_EN
        if (dr && m_wait >= MAX_WAIT) return 2;
`endif
        if (cr) return 1;
        if (dr) return 2;
        return 0;
    endfunction

    // ---------------- driver: one cycle of traffic, checked ----------------
    task automatic step(input bit cr, input bit cw, input logic [ADDR_W-1:0] ca,
                        input logic [DATA_W-1:0] cd, input bit dr, input bit dw,
                        input bit dl, input logic [ADDR_W-1:0] da,
                        input logic [DATA_W-1:0] dd);
        int                w;
        bit                we;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] wd;
        bit                exp_cv, exp_dv;
        logic [DATA_W:0]   e;
        @(negedge clk);
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dbg_req = dr; dbg_we = dw; dbg_lock = dl; dbg_addr = da; dbg_wdata = dd;
        #1;
        w  = winner(cr, dr);
        we = (w == 1) ? cw : dw;
        a  = (w == 1) ? ca : da;
        wd = (w == 1) ? cd : dd;
        check("cpu_gnt",   64'(cpu_gnt),   64'(w == 1));
        check("dbg_gnt",   64'(dbg_gnt),   64'(w == 2));
        check("owner",     64'(owner),     64'(m_locked || w == 2));
        check("mem_read",  64'(mem_read),  64'(w != 0 && !we));
        check("mem_write", 64'(mem_write), 64'(w != 0 && we));
        check("mem_addr",  64'(mem_addr),  (w != 0) ? 64'(a) : 64'd0);
        check("mem_wdata", 64'(mem_wdata), (w != 0) ? 64'(wd) : 64'd0);
        check("state",     64'(arb_state), 64'(m_locked));
        exp_cv = 1'b0;
        exp_dv = 1'b0;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e[DATA_W]) begin
                exp_dv = 1'b1;
                m_dbg_rdata = e[DATA_W-1:0];
            end else begin
                exp_cv = 1'b1;
                m_cpu_rdata = e[DATA_W-1:0];
            end
        end
        check("cpu_rvalid", 64'(cpu_rvalid), 64'(exp_cv));
        check("dbg_rvalid", 64'(dbg_rvalid), 64'(exp_dv));
        check("cpu_rdata",  64'(cpu_rdata),  64'(m_cpu_rdata));
        check("dbg_rdata",  64'(dbg_rdata),  64'(m_dbg_rdata));
        // Advance the model across the coming rising edge.
        if (w != 0) begin
            if (we) exp_mem[a[5:2]] = wd;
            else    exp_q.push_back({(w == 2), exp_mem[a[5:2]]});
        end
        if (w == 2)                         m_wait = 0;
        else if (dr && m_wait < MAX_WAIT)   m_wait++;
        m_locked = m_locked ? dl : (w == 2 && dl);
    endtask

    task automatic idle();
        step(0, 0, '0, '0, 0, 0, 0, '0, '0);
    endtask

    task automatic both_reads_held();
        step(1, 0, 32'h20, '0, 1, 0, 0, 32'h24, '0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 16; i++) exp_mem[i] = init_word(i);
        model_reset();
        reset = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_lock = 0; dbg_addr = '0; dbg_wdata = '0;

        // Reset values.
        #12;
        check("rst_cpu_rvalid", 64'(cpu_rvalid), 64'd0);
        check("rst_dbg_rvalid", 64'(dbg_rvalid), 64'd0);
        check("rst_cpu_rdata",  64'(cpu_rdata),  64'd0);
        check("rst_dbg_rdata",  64'(dbg_rdata),  64'd0);
        check("rst_owner",      64'(owner),      64'd0);
        check("rst_state",      64'(arb_state),  64'(ARB));
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("post_rst_cpu_gnt", 64'(cpu_gnt), 64'd0);
        check("post_rst_dbg_gnt", 64'(dbg_gnt), 64'd0);

        // CPU read of 0x10.
        step(1, 0, 32'h10, '0, 0, 0, 0, '0, '0);
        check("rd10_gnt",  64'(cpu_gnt),  64'd1);
        check("rd10_read", 64'(mem_read), 64'd1);
        idle();
        check("rd10_rvalid", 64'(cpu_rvalid), 64'd1);
        check("rd10_rdata",  64'(cpu_rdata),  64'hDEAD_BEEF);

        // Back-to-back CPU reads of 0x0, 0x4, 0x8.
        step(1, 0, 32'h0, '0, 0, 0, 0, '0, '0);
        step(1, 0, 32'h4, '0, 0, 0, 0, '0, '0);
        check("b2b0_rdata", 64'(cpu_rdata), 64'(init_word(0)));
        step(1, 0, 32'h8, '0, 0, 0, 0, '0, '0);
        check("b2b1_rdata", 64'(cpu_rdata), 64'(init_word(1)));
        idle();
        check("b2b2_rdata", 64'(cpu_rdata), 64'(init_word(2)));
        idle();
        check("b2b_end_rvalid", 64'(cpu_rvalid), 64'd0);

        // Same-cycle CPU write 0x4 and debug write 0x8.
        step(1, 1, 32'h4, 32'hC0DE_0004, 1, 1, 0, 32'h8, 32'hDB60_0008);
        check("coll_addr0", 64'(mem_addr), 64'h4);
        step(0, 0, '0, '0, 1, 1, 0, 32'h8, 32'hDB60_0008);
        check("coll_addr1", 64'(mem_addr), 64'h8);
        step(1, 0, 32'h4, '0, 1, 0, 0, 32'h8, '0);
        step(0, 0, '0, '0, 1, 0, 0, 32'h8, '0);
        check("coll_cpu_rd", 64'(cpu_rdata), 64'hC0DE_0004);
        idle();
        check("coll_dbg_rd", 64'(dbg_rdata), 64'hDB60_0008);

        // Locked debug access with the CPU waiting.
        step(0, 0, '0, '0, 1, 0, 1, 32'h30, '0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 32'h0, '0, 1, 1, 1, 32'h30, DATA_W'(i));
            check("lock_cpu_gnt", 64'(cpu_gnt), 64'd0);
        end
        step(1, 0, 32'h0, '0, 1, 0, 0, 32'h30, '0);
        check("unlock_cpu_gnt", 64'(cpu_gnt), 64'd0);
        step(1, 0, 32'h0, '0, 0, 0, 0, '0, '0);
        check("after_lock_cpu_gnt", 64'(cpu_gnt), 64'd1);
        idle();

        // Both ports requesting continuously.
        for (int i = 0; i < 3; i++) begin
            both_reads_held();
            check("hold_cpu_first", 64'(cpu_gnt), 64'd1);
        end
        both_reads_held();
`ifdef DMEM_ARB_STARVE_EN
        check("starve_dbg_4th", 64'(dbg_gnt), 64'd1);
`else
        check("prio_cpu_4th", 64'(cpu_gnt), 64'd1);
`endif
        both_reads_held();
        check("hold_cpu_5th", 64'(cpu_gnt), 64'd1);
        idle();
        idle();

        // Reset hits just after a locked debug read is accepted.
        step(0, 0, '0, '0, 1, 0, 1, 32'h8, '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        cpu_req = 0; dbg_req = 0; dbg_lock = 0;
        #1;
        check("rstacc_dbg_rvalid", 64'(dbg_rvalid), 64'd0);
        check("rstacc_owner",      64'(owner),      64'd0);
        check("rstacc_state",      64'(arb_state),  64'(ARB));
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rstacc_first_gnt", 64'({cpu_gnt, dbg_gnt}), 64'd0);
        check("rstacc_first_rv",  64'(dbg_rvalid), 64'd0);
        idle();
        idle();

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            bit cr, cw, dr, dw, dl;
            cr = ($urandom_range(1) == 1);
            cw = ($urandom_range(1) == 1);
            dr = ($urandom_range(1) == 1);
            dw = ($urandom_range(1) == 1);
            dl = m_locked ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
            step(cr, cw, ADDR_W'($urandom_range(15) * 4), DATA_W'($urandom),
                 dr, dw, dl, ADDR_W'($urandom_range(15) * 4), DATA_W'($urandom));
        end
        idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, the address width of all ports.
REQ-002 SHALL have parameter DATA_W, default 32, the data width of all ports.
REQ-003 SHALL have parameter MAX_WAIT, default 8, the debug-port starvation limit in cycles (range 1..255).
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-006 SHALL have ports cpu_req/cpu_we, input, 1 each, the CPU access request and write select.
REQ-007 SHALL have ports cpu_addr (ADDR_W) and cpu_wdata (DATA_W), inputs, the CPU address and write data.
REQ-008 SHALL have ports cpu_gnt/cpu_rvalid (1) and cpu_rdata (DATA_W), outputs, the CPU grant, read-valid and read data.
REQ-009 SHALL have ports dbg_req/dbg_we/dbg_lock (1), dbg_addr (ADDR_W) and dbg_wdata (DATA_W), inputs, the debug-loader request set; dbg_lock is a bus hold.
REQ-010 SHALL have ports dbg_gnt/dbg_rvalid (1) and dbg_rdata (DATA_W), outputs, the debug grant, read-valid and read data.
REQ-011 SHALL have ports mem_read/mem_write (1), mem_addr (ADDR_W) and mem_wdata (DATA_W), outputs, plus mem_rdata (DATA_W), input, all to the data memory (combinational read, clocked write).
REQ-012 SHALL have port owner, output, 1, the current bus owner (0 = CPU, 1 = debug).

Function
REQ-013 SHALL accept an access when req && gnt is high at a rising edge; at most one access per cycle; back-to-back accesses allowed.
REQ-014 SHALL generate gnt combinationally from the requests and registered state; at most one gnt high per cycle.
REQ-015 SHALL drive mem_* from the granted port's inputs in the same cycle; mem_read = gnt && !we, mem_write = gnt && we; all mem_* are 0 with no grant.
REQ-016 SHALL register read data at the accept edge and raise the owner's rvalid for exactly one cycle after it; rdata holds its value until the next read.
REQ-017 SHALL complete writes at the accept edge with no rvalid.
REQ-018 SHALL use FSM states ARB and DBG_LOCK.
REQ-019 SHALL, in ARB, grant the CPU when cpu_req is high, otherwise the debug port when dbg_req is high.
REQ-020 SHALL move ARB -> DBG_LOCK on an accepted debug access with dbg_lock = 1.
REQ-021 SHALL, in DBG_LOCK, grant only the debug port (cpu_gnt = 0) and return to ARB at the first edge where dbg_lock = 0.
REQ-022 SHALL drive owner = 1 in DBG_LOCK or during a debug grant, and 0 otherwise.
REQ-023 SHALL grant the CPU on a same-cycle request by both ports in ARB, unless REQ-029 applies.

Reset
REQ-024 SHALL, when reset is low, force state ARB, cpu_rvalid = dbg_rvalid = 0, cpu_rdata = dbg_rdata = 0, owner = 0 and wait counter = 0, asynchronously.
REQ-025 SHALL drop any read pending when reset asserts: no rvalid after deassertion.
REQ-026 SHALL grant nothing in the first cycle after deassertion when no request is present.

Configuration
REQ-027 SHALL compile the starvation guard only when macro DMEM_ARB_STARVE_EN is defined.
REQ-028 SHALL, with DMEM_ARB_STARVE_EN, count cycles where dbg_req is high and dbg_gnt is low, saturating at MAX_WAIT, and clear the count on any debug accept.
REQ-029 SHALL, with DMEM_ARB_STARVE_EN and count = MAX_WAIT, grant the debug port over the CPU in ARB.
REQ-030 SHALL, without the macro, use strict CPU priority in ARB and contain no counter logic.

Structure
REQ-031 SHALL place the state enum (ARB, DBG_LOCK), the owner encoding and the default widths in shared package dmem_arb_pkg.
REQ-032 SHALL place the starvation counter in sub-module dmem_arb_wait_cnt, instantiated only under DMEM_ARB_STARVE_EN.

Verification
REQ-033 SHALL cover a CPU read of 0x10 with mem_rdata = 0xDEADBEEF -> cpu_gnt and mem_read in the same cycle, then cpu_rvalid = 1 and cpu_rdata = 0xDEADBEEF one cycle later.
REQ-034 SHALL cover a same-cycle CPU write of 0x4 and debug write of 0x8 -> CPU granted first, debug granted the next cycle, mem_addr 0x4 then 0x8.
REQ-035 SHALL cover a debug access with dbg_lock = 1 for 4 cycles while cpu_req is held -> cpu_gnt = 0 throughout and the CPU granted the cycle after dbg_lock falls.
REQ-036 SHALL cover, with DMEM_ARB_STARVE_EN and MAX_WAIT = 3, cpu_req and dbg_req held continuously -> debug granted in the 4th cycle, then the CPU again.
REQ-037 SHALL cover reset asserted in the cycle a debug read is accepted -> no dbg_rvalid afterwards, owner = 0, state ARB.
REQ-038 SHALL cover back-to-back CPU reads of 0x0, 0x4 and 0x8 -> three consecutive single-cycle cpu_rvalid pulses with matching data.
